pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: TIMEOUT_CYCLES, 16, fetch watchdog limit (1..255); used only with FETCH_TIMEOUT_EN.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  in  1  reset, synchronous and active-low.
REQ-005 Port: next_PC  in  32  next PC from the PC source select stage.
REQ-006 Port: stall  in  1  hold the current instruction; no PC update.
REQ-007 Port: imem_ready  in  1  instruction memory has data for imem_addr this cycle.
REQ-008 Port: imem_rdata  in  32  instruction word, valid when imem_ready=1.
REQ-009 Port: PC  out  32  current program counter (registered).
REQ-010 Port: PCPlus4  out  32  PC+4, combinational, modulo 2^32.
REQ-011 Port: imem_req  out  1  fetch request.
REQ-012 Port: imem_addr  out  32  fetch address, equal to PC.
REQ-013 Port: Instr  out  32  latched instruction word.
REQ-014 Port: instr_valid  out  1  Instr valid for the datapath.
REQ-015 Port: retired  out  32  count of completed instructions.
REQ-016 Port: misaligned  out  1  sticky: next_PC[1:0]!=0 rejected.
REQ-017 Port: fetch_timeout  out  1  sticky watchdog flag.

Function
REQ-018 FSM states: FETCH, EXEC, HALT; encoding is free.
REQ-019 FETCH: imem_req=1, imem_addr=PC, instr_valid=0; when imem_ready=1, Instr<=imem_rdata and state<=EXEC on the same edge.
REQ-020 FETCH with imem_ready=0: remain in FETCH, PC and Instr unchanged.
REQ-021 EXEC: imem_req=0, instr_valid=1 every cycle in EXEC.
REQ-022 EXEC with stall=1: remain in EXEC; PC, Instr and retired held.
REQ-023 EXEC with stall=0 and next_PC[1:0]==2'b00: PC<=next_PC, retired<=retired+1, state<=FETCH.
REQ-024 EXEC with stall=0 and next_PC[1:0]!=2'b00: PC held, retired<=retired+1, misaligned<=1, state<=HALT.
REQ-025 HALT: imem_req=0, instr_valid=0, all registers held; exited only by reset.
REQ-026 retired wraps from 32'hFFFF_FFFF to 0; PCPlus4 of 32'hFFFF_FFFC is 0.
REQ-027 In FETCH, stall is ignored; in HALT, stall and imem_ready are ignored.
REQ-028 Minimum per-instruction latency: 2 cycles (FETCH with imem_ready=1, then EXEC with stall=0).

Reset
REQ-029 rst_n=0 sampled at a clock edge: PC<=RESET_PC, Instr<=0, retired<=0, misaligned<=0, fetch_timeout<=0, watchdog<=0, state<=FETCH.
REQ-030 Reset overrides any state, including a pending imem_ready or a mid-stall EXEC; no retired increment occurs on the reset edge.
REQ-031 First imem_req=1 occurs in the first cycle after rst_n returns high, with imem_addr=RESET_PC.

Configuration
REQ-032 Macro FETCH_TIMEOUT_EN defined: an 8-bit watchdog counts FETCH cycles with imem_ready=0 and clears on leaving FETCH.
REQ-033 With FETCH_TIMEOUT_EN, when the watchdog reaches TIMEOUT_CYCLES with imem_ready still 0: fetch_timeout<=1 and state<=HALT.
REQ-034 Macro undefined: no watchdog logic, fetch_timeout tied to 0, and FETCH waits indefinitely.

Verification
REQ-035 Reset with RESET_PC=0, imem_ready=1, imem_rdata=32'h2008_0005, next_PC=32'h4, stall=0 -> Instr=32'h2008_0005, instr_valid=1 in cycle 2, PC=32'h4 and retired=1 in cycle 3.
REQ-036 EXEC with stall=1 for 5 cycles -> instr_valid=1, PC and retired constant; first cycle after stall drops -> PC=next_PC.
REQ-037 imem_ready low for 3 FETCH cycles -> imem_req=1 and imem_addr=PC throughout; Instr updates only on the ready cycle.
REQ-038 next_PC=32'h0000_1002 in EXEC -> misaligned=1, PC held, then HALT with imem_req=0 until rst_n=0.
REQ-039 FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=16 and imem_ready held 0 -> fetch_timeout=1 and HALT after 16 FETCH cycles; same stimulus without the macro -> still in FETCH after 100 cycles.
REQ-040 rst_n=0 during a stalled EXEC at PC=32'h0000_2000 -> next cycle PC=RESET_PC, retired=0, imem_req=1.

Source files
------------

// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC register, FETCH/EXEC/HALT sequencing and retired-instruction count.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module pc_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_PC,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] Instr,
    output logic        instr_valid,
    output logic [31:0] retired,
    output logic        misaligned,
    output logic        fetch_timeout
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t state;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("pc_fetch: TIMEOUT_CYCLES must be in 1..255");
    end

    assign PCPlus4   = PC + 32'd4;
    assign imem_addr = PC;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wdog;
`endif

    // imem_req / instr_valid are registered alongside the state they decode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            PC          <= RESET_PC;
            Instr       <= 32'd0;
            retired     <= 32'd0;
            misaligned  <= 1'b0;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wdog          <= 8'd0;
            fetch_timeout <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (imem_ready) begin
                        Instr       <= imem_rdata;
                        state       <= S_EXEC;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        wdog        <= 8'd0;
`endif
                    end
`ifdef FETCH_TIMEOUT_EN
                    // watchdog trips on the TIMEOUT_CYCLES-th consecutive not-ready cycle
                    else if (wdog == TIMEOUT_LAST) begin
                        fetch_timeout <= 1'b1;
                        state         <= S_HALT;
                        imem_req      <= 1'b0;
                        wdog          <= 8'd0;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
`endif
                end
                S_EXEC: begin
                    if (!stall) begin
                        retired     <= retired + 32'd1;
                        instr_valid <= 1'b0;
                        if (next_PC[1:0] == 2'b00) begin
                            PC       <= next_PC;
                            state    <= S_FETCH;
                            imem_req <= 1'b1;
                        end else begin
                            misaligned <= 1'b1;
                            state      <= S_HALT;
                        end
                    end
                end
                S_HALT: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

`ifndef FETCH_TIMEOUT_EN
    assign fetch_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: scoreboard of expected instruction words plus per-scenario checks.
// Timeout scenario follows FETCH_TIMEOUT_EN.
module tb_pc_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] next_PC;
    logic        stall;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] Instr;
    logic        instr_valid;
    logic [31:0] retired;
    logic        misaligned;
    logic        fetch_timeout;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;
    logic [31:0] exp_instr;

    pc_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .next_PC(next_PC), .stall(stall),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .PC(PC), .PCPlus4(PCPlus4),
        .imem_req(imem_req), .imem_addr(imem_addr), .Instr(Instr),
        .instr_valid(instr_valid), .retired(retired), .misaligned(misaligned),
        .fetch_timeout(fetch_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_pc  = 32'h0;
        exp_ret = 32'h0;
        exp_instr = 32'h0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF; stall = 1'b1; next_PC = 32'h40;
        tick(); tick();
        n_cmp++; if (PC !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", PC, 32'h0); end
        n_cmp++; if (Instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want %h", Instr, 32'h0); end
        n_cmp++; if (retired !== 32'h0) begin n_err++; $display("FAIL reset_retired: got %h want 0", retired); end
        n_cmp++; if ({imem_req, instr_valid, misaligned, fetch_timeout} !== 4'b1000)
            begin n_err++; $display("FAIL reset_flags: got %b want 1000", {imem_req, instr_valid, misaligned, fetch_timeout}); end
        rst_n = 1'b1;
        exp_pc = 32'h0; exp_ret = 32'h0; exp_instr = 32'h0;
    endtask

    // REQ-035 style first instruction: Instr valid in cycle 2, PC/retired updated in cycle 3
    task automatic test_basic();
        imem_ready = 1'b1; imem_rdata = 32'h2008_0005; next_PC = 32'h4; stall = 1'b0;
        exp_q.push_back(32'h2008_0005);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
            begin n_err++; $display("FAIL first_req: got req=%b addr=%h want 1/%h", imem_req, imem_addr, 32'h0); end
        tick();
        n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", instr_valid); end
        if (exp_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL basic_sb: queue empty"); end
        else begin
            exp_instr = exp_q.pop_front();
            n_cmp++; if (Instr !== exp_instr) begin n_err++; $display("FAIL basic_instr: got %h want %h", Instr, exp_instr); end
        end
        tick();
        exp_pc = 32'h4; exp_ret = 32'd1;
        n_cmp++; if (PC !== exp_pc || retired !== exp_ret)
            begin n_err++; $display("FAIL basic_commit: got pc=%h ret=%0d want %h/%0d", PC, retired, exp_pc, exp_ret); end
        n_cmp++; if (PCPlus4 !== 32'h8) begin n_err++; $display("FAIL basic_pcplus4: got %h want %h", PCPlus4, 32'h8); end
        n_cmp++; if (imem_req !== 1'b1 || instr_valid !== 1'b0)
            begin n_err++; $display("FAIL basic_refetch: got req=%b valid=%b want 1/0", imem_req, instr_valid); end
    endtask

    task automatic test_stall();
        imem_ready = 1'b1; imem_rdata = 32'h1111_2222; stall = 1'b0; next_PC = 32'h100;
        exp_q.push_back(32'h1111_2222);
        tick();
        if (exp_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL stall_sb: queue empty"); end
        else begin
            exp_instr = exp_q.pop_front();
            n_cmp++; if (Instr !== exp_instr) begin n_err++; $display("FAIL stall_instr: got %h want %h", Instr, exp_instr); end
        end
        stall = 1'b1; imem_rdata = 32'h9999_9999;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (instr_valid !== 1'b1 || PC !== exp_pc || retired !== exp_ret || Instr !== exp_instr)
                begin n_err++; $display("FAIL stall_hold%0d: got v=%b pc=%h ret=%0d instr=%h want 1/%h/%0d/%h",
                                        i, instr_valid, PC, retired, Instr, exp_pc, exp_ret, exp_instr); end
        end
        stall = 1'b0;
        tick();
        exp_pc = 32'h100; exp_ret = exp_ret + 32'd1;
        n_cmp++; if (PC !== exp_pc || retired !== exp_ret)
            begin n_err++; $display("FAIL stall_release: got pc=%h ret=%0d want %h/%0d", PC, retired, exp_pc, exp_ret); end
    endtask

    task automatic test_not_ready();
        imem_ready = 1'b0; imem_rdata = 32'hBAD0_BAD0; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0 || Instr !== exp_instr)
                begin n_err++; $display("FAIL wait%0d: got req=%b addr=%h v=%b instr=%h want 1/%h/0/%h",
                                        i, imem_req, imem_addr, instr_valid, Instr, exp_pc, exp_instr); end
        end
        imem_ready = 1'b1; imem_rdata = 32'h3333_4444; stall = 1'b0; next_PC = 32'h2000;
        exp_q.push_back(32'h3333_4444);
        tick();
        if (exp_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL wait_sb: queue empty"); end
        else begin
            exp_instr = exp_q.pop_front();
            n_cmp++; if (Instr !== exp_instr || instr_valid !== 1'b1)
                begin n_err++; $display("FAIL wait_instr: got %h v=%b want %h/1", Instr, instr_valid, exp_instr); end
        end
        tick();
        exp_pc = 32'h2000; exp_ret = exp_ret + 32'd1;
        n_cmp++; if (PC !== exp_pc || retired !== exp_ret)
            begin n_err++; $display("FAIL wait_commit: got pc=%h ret=%0d want %h/%0d", PC, retired, exp_pc, exp_ret); end
    endtask

    task automatic test_reset_mid_stall();
        imem_ready = 1'b1; imem_rdata = 32'h5555_6666; stall = 1'b1;
        tick(); tick();
        n_cmp++; if (PC !== 32'h2000 || instr_valid !== 1'b1)
            begin n_err++; $display("FAIL midstall_pre: got pc=%h v=%b want %h/1", PC, instr_valid, 32'h2000); end
        stall = 1'b0;
        do_reset();
        n_cmp++; if (PC !== 32'h0 || retired !== 32'h0 || imem_req !== 1'b1 || instr_valid !== 1'b0)
            begin n_err++; $display("FAIL midstall_reset: got pc=%h ret=%0d req=%b v=%b want 0/0/1/0",
                                    PC, retired, imem_req, instr_valid); end
    endtask

    task automatic test_misaligned();
        imem_ready = 1'b1; imem_rdata = 32'h7777_8888; stall = 1'b0; next_PC = 32'h0000_1002;
        tick();
        tick();
        n_cmp++; if (misaligned !== 1'b1 || PC !== 32'h0 || retired !== 32'd1)
            begin n_err++; $display("FAIL misal_flag: got m=%b pc=%h ret=%0d want 1/0/1", misaligned, PC, retired); end
        for (int i = 0; i < 4; i++) begin
            next_PC = 32'h40; stall = i[0];
            tick();
            n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || PC !== 32'h0 || retired !== 32'd1 || misaligned !== 1'b1)
                begin n_err++; $display("FAIL halt_hold%0d: got req=%b v=%b pc=%h ret=%0d m=%b want 0/0/0/1/1",
                                        i, imem_req, instr_valid, PC, retired, misaligned); end
        end
        do_reset();
        n_cmp++; if (misaligned !== 1'b0 || imem_req !== 1'b1)
            begin n_err++; $display("FAIL halt_exit: got m=%b req=%b want 0/1", misaligned, imem_req); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        stall = 1'b0; imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            imem_rdata = w;
            next_PC = (i == 3) ? 32'hFFFF_FFFC : exp_pc + 32'h10;
            exp_q.push_back(w);
            tick();
            if (exp_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL b2b_sb%0d: queue empty", i); end
            else begin
                exp_instr = exp_q.pop_front();
                n_cmp++; if (Instr !== exp_instr) begin n_err++; $display("FAIL b2b_instr%0d: got %h want %h", i, Instr, exp_instr); end
            end
            tick();
            exp_pc = next_PC; exp_ret = exp_ret + 32'd1;
            n_cmp++; if (PC !== exp_pc || retired !== exp_ret)
                begin n_err++; $display("FAIL b2b_commit%0d: got pc=%h ret=%0d want %h/%0d", i, PC, retired, exp_pc, exp_ret); end
        end
        n_cmp++; if (PCPlus4 !== 32'h0) begin n_err++; $display("FAIL pcplus4_wrap: got %h want 0", PCPlus4); end
    endtask

    task automatic test_timeout();
        do_reset();
        imem_ready = 1'b0; stall = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        repeat (15) tick();
        n_cmp++; if (fetch_timeout !== 1'b0 || imem_req !== 1'b1)
            begin n_err++; $display("FAIL wd_early: got to=%b req=%b want 0/1", fetch_timeout, imem_req); end
        tick();
        n_cmp++; if (fetch_timeout !== 1'b1 || imem_req !== 1'b0)
            begin n_err++; $display("FAIL wd_trip: got to=%b req=%b want 1/0", fetch_timeout, imem_req); end
        imem_ready = 1'b1;
        tick();
        n_cmp++; if (instr_valid !== 1'b0 || imem_req !== 1'b0)
            begin n_err++; $display("FAIL wd_halt: got v=%b req=%b want 0/0", instr_valid, imem_req); end
`else
        repeat (100) tick();
        n_cmp++; if (fetch_timeout !== 1'b0 || imem_req !== 1'b1 || instr_valid !== 1'b0 || PC !== 32'h0)
            begin n_err++; $display("FAIL no_wd: got to=%b req=%b v=%b pc=%h want 0/1/0/0",
                                    fetch_timeout, imem_req, instr_valid, PC); end
`endif
        do_reset();
    endtask

    initial begin
        rst_n = 1'b0; next_PC = 32'h0; stall = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
        exp_pc = 32'h0; exp_ret = 32'h0; exp_instr = 32'h0;
        test_reset();
        test_basic();
        test_stall();
        test_not_ready();
        test_reset_mid_stall();
        test_misaligned();
        test_back_to_back();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
